// File: rtl/i386_bus_pkg.sv
// Shared types and constants for the i386-style bus master.
// Optional T2 timeout is enabled with I386_BUS_TIMEOUT_EN.
package i386_bus_pkg;

    localparam int BUS_ADDR_W = 23;
    localparam int BUS_DATA_W = 32;

    localparam logic [3:0]            BE_NONE    = 4'hF;
    localparam logic [BUS_DATA_W-1:0] ABORT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        T1,
        T2,
        RESP
    } bus_state_e;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [3:0]            be;
        logic                  wr;
        logic                  mio;
        logic                  lock;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/i386_wait_timer.sv
// Counts T2 wait cycles and flags the edge on which the limit is reached.
// Only instantiated when I386_BUS_TIMEOUT_EN is defined.
module i386_wait_timer #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // Wait counter: cleared in T1, advances on each unanswered T2 cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expires on the edge whose increment would reach LIMIT
    assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/i386_bus_master.sv
// Non-pipelined 80386DX-style bus-cycle initiator (T1, T2..., RESP).
// Define I386_BUS_TIMEOUT_EN to abort T2 after TIMEOUT_CYCLES waits.
module i386_bus_master
    import i386_bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic              req_wr,
    input  logic              req_mio,
    input  logic              req_lock,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ADDR,
    output logic [3:0]        BE,
    output logic              ADS,
    output logic              MIO,
    output logic              WR,
    output logic              LOCK,
    input  logic              READY,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OE
);

    bus_state_e state_q;
    bus_req_t   req_q;
    logic       to_expired;

    if (TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_bad_cfg
        $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef I386_BUS_TIMEOUT_EN
    i386_wait_timer #(
        .CNT_W (TO_CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .clear_i   (state_q == T1),
        .en_i      ((state_q == T2) && READY),
        .expired_o (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    // Bus-cycle FSM; every bus and response output is a register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ADDR      <= '0;
            BE        <= BE_NONE;
            ADS       <= 1'b1;
            MIO       <= 1'b0;
            WR        <= 1'b0;
            LOCK      <= 1'b1;
            DATA_OUT  <= '0;
            DATA_OE   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q.addr  <= req_addr;
                        req_q.be    <= req_be;
                        req_q.wr    <= req_wr;
                        req_q.mio   <= req_mio;
                        req_q.lock  <= req_lock;
                        req_q.wdata <= req_wdata;
                        req_ready   <= 1'b0;
                        if (req_be != 4'h0) begin
                            state_q <= T1;
                            ADS     <= 1'b0;
                            ADDR    <= req_addr;
                            BE      <= ~req_be;
                            WR      <= req_wr;
                            MIO     <= req_mio;
                            LOCK    <= ~req_lock;
                            DATA_OE <= req_wr;
                            if (req_wr) begin
                                DATA_OUT <= req_wdata;
                            end
                        end else begin
                            // Empty byte mask: fail without a bus cycle
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                T1: begin
                    // Re-drive from the latch so T2 holds the same fields
                    state_q <= T2;
                    ADS     <= 1'b1;
                    ADDR    <= req_q.addr;
                    BE      <= ~req_q.be;
                    WR      <= req_q.wr;
                    MIO     <= req_q.mio;
                    LOCK    <= ~req_q.lock;
                    if (req_q.wr) begin
                        DATA_OUT <= req_q.wdata;
                    end
                end
                T2: begin
                    if (!READY) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= req_q.wr ? '0 : DATA_IN;
                        DATA_OE   <= 1'b0;
                        BE        <= BE_NONE;
                    end else if (to_expired) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= ABORT_DATA;
                        DATA_OE   <= 1'b0;
                        BE        <= BE_NONE;
                        LOCK      <= 1'b1;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i386_bus_master.sv
// Directed bench for i386_bus_master with a response scoreboard.
// Timeout steps run only when I386_BUS_TIMEOUT_EN is defined.
module tb_i386_bus_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [22:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic        req_wr = 1'b0;
    logic        req_mio = 1'b0;
    logic        req_lock = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [22:0] ADDR;
    logic [3:0]  BE;
    logic        ADS;
    logic        MIO;
    logic        WR;
    logic        LOCK;
    logic        READY = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic [31:0] DATA_OUT;
    logic        DATA_OE;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    i386_bus_master #(
        .TIMEOUT_CYCLES (8),
        .TO_CNT_W       (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wr    (req_wr),
        .req_mio   (req_mio),
        .req_lock  (req_lock),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ADDR      (ADDR),
        .BE        (BE),
        .ADS       (ADS),
        .MIO       (MIO),
        .WR        (WR),
        .LOCK      (LOCK),
        .READY     (READY),
        .DATA_IN   (DATA_IN),
        .DATA_OUT  (DATA_OUT),
        .DATA_OE   (DATA_OE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response must match the oldest request
    always @(negedge CLK) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Called at a negedge; returns just after the accept edge
    task automatic issue(input logic [22:0] a, input logic [3:0] be,
                         input logic wr, input logic mio, input logic lk,
                         input logic [31:0] wd, input logic [31:0] erd,
                         input logic eerr);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("issue_ready", {31'd0, req_ready}, 32'd1);
        req_addr  = a;
        req_be    = be;
        req_wr    = wr;
        req_mio   = mio;
        req_lock  = lk;
        req_wdata = wd;
        req_valid = 1'b1;
        sb.push_back('{rdata: erd, err: eerr});
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input logic do_lock, input logic exp_lock);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (do_lock) begin
                chk("lock_hold", {31'd0, LOCK}, {31'd0, exp_lock});
            end
        end while (req_ready !== 1'b1 && n < 50);
        chk("idle_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ads"}, {31'd0, ADS}, 32'd1);
        chk({tag, "_be"}, {28'd0, BE}, 32'hF);
        chk({tag, "_lock"}, {31'd0, LOCK}, 32'd1);
        chk({tag, "_oe"}, {31'd0, DATA_OE}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rspv"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_vals("rst");
        RESET = 1'b0;
        @(negedge CLK);

        // Zero-wait read
        DATA_IN = 32'hDEAD_BEEF;
        READY   = 1'b0;
        issue(23'h000100, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,
              32'hDEAD_BEEF, 1'b0);
        @(negedge CLK);
        chk("rd_t1_ads", {31'd0, ADS}, 32'd0);
        chk("rd_t1_addr", {9'd0, ADDR}, 32'h100);
        chk("rd_t1_be", {28'd0, BE}, 32'h0);
        chk("rd_t1_wr", {31'd0, WR}, 32'd0);
        chk("rd_t1_mio", {31'd0, MIO}, 32'd1);
        chk("rd_t1_rdy", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        chk("rd_t2_ads", {31'd0, ADS}, 32'd1);
        chk("rd_t2_rspv", {31'd0, rsp_valid}, 32'd0);
        @(negedge CLK);
        chk("rd_c3_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("rd_c3_be", {28'd0, BE}, 32'hF);
        chk("rd_c3_ads", {31'd0, ADS}, 32'd1);
        @(negedge CLK);
        chk("rd_c4_rdy", {31'd0, req_ready}, 32'd1);
        chk("rd_c4_rspv", {31'd0, rsp_valid}, 32'd0);

        // Write with three wait states
        READY = 1'b1;
        issue(23'h0002A0, 4'b0011, 1'b1, 1'b1, 1'b0, 32'h1234_5678,
              32'h0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            chk("wr_oe", {31'd0, DATA_OE}, (c <= 5) ? 32'd1 : 32'd0);
            chk("wr_ads", {31'd0, ADS}, (c == 1) ? 32'd0 : 32'd1);
            chk("wr_rspv", {31'd0, rsp_valid}, (c == 6) ? 32'd1 : 32'd0);
            if (c <= 5) begin
                chk("wr_dout", DATA_OUT, 32'h1234_5678);
                chk("wr_be", {28'd0, BE}, 32'hC);
                chk("wr_wr", {31'd0, WR}, 32'd1);
            end
            if (c == 7) begin
                chk("wr_c7_rdy", {31'd0, req_ready}, 32'd1);
            end
            READY = (c == 5) ? 1'b0 : 1'b1;
        end
        READY = 1'b0;

        // Locked sequence: lock, lock, unlock
        DATA_IN = 32'h0BAD_F00D;
        issue(23'h000010, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0,
              32'h0BAD_F00D, 1'b0);
        @(negedge CLK);
        chk("lk_a_t1", {31'd0, LOCK}, 32'd0);
        wait_idle(1'b1, 1'b0);
        repeat (2) begin
            @(negedge CLK);
            chk("lk_idle", {31'd0, LOCK}, 32'd0);
        end
        issue(23'h000020, 4'hF, 1'b1, 1'b1, 1'b1, 32'hAAAA_5555,
              32'h0, 1'b0);
        @(negedge CLK);
        chk("lk_b_t1", {31'd0, LOCK}, 32'd0);
        wait_idle(1'b1, 1'b0);
        DATA_IN = 32'h5A5A_0001;
        issue(23'h000030, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
              32'h5A5A_0001, 1'b0);
        @(negedge CLK);
        chk("lk_c_t1", {31'd0, LOCK}, 32'd1);
        chk("lk_c_mio", {31'd0, MIO}, 32'd0);
        wait_idle(1'b0, 1'b0);

        // Empty byte mask: error, no bus activity
        issue(23'h000040, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge CLK);
        chk("be0_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("be0_ads1", {31'd0, ADS}, 32'd1);
        @(negedge CLK);
        chk("be0_ads2", {31'd0, ADS}, 32'd1);
        chk("be0_rdy", {31'd0, req_ready}, 32'd1);

        // Reset during T2 drops the transaction silently
        READY = 1'b1;
        issue(23'h000050, 4'hF, 1'b1, 1'b1, 1'b1, 32'h7777_8888,
              32'h0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_t2_ads", {31'd0, ADS}, 32'd1);
        chk("mid_t2_oe", {31'd0, DATA_OE}, 32'd1);
        RESET = 1'b1;
        void'(sb.pop_back());
        @(negedge CLK);
        chk_reset_vals("mid");
        RESET = 1'b0;
        READY = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

`ifdef I386_BUS_TIMEOUT_EN
        // Timeout after 8 unanswered T2 cycles
        READY = 1'b1;
        issue(23'h000060, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0,
              32'hFFFF_FFFF, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            chk("to_rspv", {31'd0, rsp_valid}, (c == 10) ? 32'd1 : 32'd0);
            if (c == 10) begin
                chk("to_lock", {31'd0, LOCK}, 32'd1);
                chk("to_oe", {31'd0, DATA_OE}, 32'd0);
            end
        end
        // READY on the 8th T2 beats the timeout
        DATA_IN = 32'hCAFE_F00D;
        issue(23'h000070, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,
              32'hCAFE_F00D, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            chk("to8_rspv", {31'd0, rsp_valid}, (c == 10) ? 32'd1 : 32'd0);
            if (c == 9) begin
                READY = 1'b0;
            end
        end
        wait_idle(1'b0, 1'b0);
`endif

        repeat (2) @(negedge CLK);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
